csnc_rx_collector: RTL
======================

Name: csnc_rx_collector

Overview:
Receive-side front end for the k=3/n=5 cyclic-shift XOR network code. It accepts role-tagged 12-bit coded packets from the channel, in any order and with erasures. Per generation it discards corrupted, duplicate and illegal packets and buffers the first K distinct valid packets. It then streams them, in ascending role order with tlast on the K-th beat, into the erasure decoder (csnc_dec_k3_l12_erasure).

Parameters:
LIN, 11, payload width before parity lift
LOUT, 12, coded packet width ({parity, payload})
K, 3, packets needed to decode
N, 5, packets per generation (roles 0..N-1: d0,d1,d2,p0,p1)
ROLE_W, 3, role field width
TIMEOUT_CYC, 1024, idle cycles in COLLECT (count>0) before the generation is abandoned; 0 disables
CNT_W, 16, statistics counter width

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axis_tdata  in  LOUT  coded packet from channel
s_axis_role  in  ROLE_W  packet role
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last packet the channel sends for this generation
m_axis_tdata  out  LOUT  packet to decoder
m_axis_role  out  ROLE_W  role of output packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  decoder ready
m_axis_tlast  out  1  high on K-th output beat
gen_ok  out  1  one-cycle pulse when the K-th beat is accepted
gen_fail  out  1  one-cycle pulse when a generation is abandoned
ok_cnt  out  CNT_W  saturating count of gen_ok
fail_cnt  out  CNT_W  saturating count of gen_fail
drop_cnt  out  CNT_W  saturating count of dropped beats (parity error, role>=N, duplicate)
par_err_cnt  out  CNT_W  saturating count of parity-error beats

Behaviour:
- Single clock aclk. Reset is synchronous and active-high on areset.
- Reset: state=COLLECT; bitmap=0; count=0; all outputs 0 except s_axis_tready=1; all counters 0. Reset overrides any in-flight emission. The next cycle shows m_axis_tvalid=0.
- Beat acceptance: s_axis_tvalid & s_axis_tready.
- Valid beat: tdata[LOUT-1] == ^tdata[LIN-1:0], role<N, and bitmap[role]==0.
- Invalid beat: dropped and drop_cnt++. On parity failure, par_err_cnt++ as well.
- COLLECT (s_axis_tready=1):
  - A valid beat is stored at buf[role], sets bitmap[role] and increments count.
  - If count reaches K on this beat: go to EMIT. Record whether tlast was set on it (last_seen).
  - Else if the accepted beat has tlast: gen_fail pulse, fail_cnt++, clear bitmap/count, stay in COLLECT. This applies whether the tlast beat was valid or dropped.
  - Timeout counter resets on every accepted beat. It counts only while count>0. On reaching TIMEOUT_CYC: gen_fail, clear, stay in COLLECT.
- EMIT (s_axis_tready=0):
  - Outputs are registered. m_axis_tvalid rises the cycle after the K-th valid beat is accepted.
  - A picker selects the lowest set bitmap bit, drives buf[role] and the role, and clears that bit on handshake.
  - Beats go out back-to-back while m_axis_tready=1. Data and role are held stable while stalled.
  - m_axis_tlast is set on the K-th beat.
  - On the K-th handshake: gen_ok pulse, ok_cnt++, count=0. Next state is COLLECT if last_seen, else DISCARD.
- DISCARD (s_axis_tready=1): every beat is dropped silently (no drop_cnt). Accepting a tlast beat returns the block to COLLECT.
- Simultaneous events: the K-th valid beat with tlast goes directly to EMIT and then to COLLECT. A beat that times out in the same cycle it is accepted counts as accepted (no timeout).
- Counters saturate at all-ones.
- Throughput: K beats in, then K+1 cycles minimum before the next beat is accepted.

Decomposition:
- csnc_pkg:
  - constants LIN, LOUT, K, N, ROLE_W
  - role enum ROLE_D0..ROLE_P1
  - state typedef {COLLECT, EMIT, DISCARD}
  - function parity_ok(pkt)
  - function lift(x) = {^x, x}, shared with the encoder
- Sub-module csnc_role_buf:
  - N x LOUT storage and bitmap
  - popcount and lowest-set-bit picker
  - clear-bit-on-pop and clear-all ports

Test Plan:
- Roles 0,1,2,3,4 from the encoder (tlast on role 4): output beats are roles 0,1,2 with data identical to input, tlast on beat 3, one gen_ok. Roles 3,4 are discarded with drop_cnt=0. State returns to COLLECT.
- Erasure: roles 4,1,3 (tlast on 3): output order 1,3,4. m_axis_tvalid rises 1 cycle after role 3 is accepted. ok_cnt=1.
- Roles 3,3,6,0,2 (tlast on 2): drop_cnt=2; output 0,2,3; gen_ok=1.
- Roles 0,1,2 with role 1 MSB flipped, tlast on 2: par_err_cnt=1, drop_cnt=1, no output beat, gen_fail pulse, fail_cnt=1.
- m_axis_tready pattern 0,1,0,1,1 during EMIT: beats held stable while low, s_axis_tready=0 throughout EMIT, and exactly 3 handshakes.
- TIMEOUT_CYC=16, two valid beats then idle: gen_fail on the 16th idle cycle.
- areset during EMIT after beat 1: m_axis_tvalid=0 next cycle and all counters 0. A following full generation decodes correctly.

Source files
------------

// File: rtl/csnc_pkg.sv
// csnc_pkg: shared constants, types and helpers for the k=3/n=5
// cyclic-shift XOR network code receive path.
//   LIN/LOUT : payload width before/after the parity lift
//   K/N      : packets needed to decode / packets per generation
//   ROLE_W   : role field width, POP_W : width of a 0..N population count
package csnc_pkg;

    localparam int LIN    = 11;
    localparam int LOUT   = 12;
    localparam int K      = 3;
    localparam int N      = 5;
    localparam int ROLE_W = 3;
    localparam int POP_W  = $clog2(N + 1);

    typedef enum logic [ROLE_W-1:0] {
        ROLE_D0 = 3'd0,
        ROLE_D1 = 3'd1,
        ROLE_D2 = 3'd2,
        ROLE_P0 = 3'd3,
        ROLE_P1 = 3'd4
    } role_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Packet MSB carries even parity over the payload bits.
    function automatic logic parity_ok(input logic [LOUT-1:0] pkt);
        return pkt[LOUT-1] == (^pkt[LIN-1:0]);
    endfunction

    // Parity lift applied by the encoder; the receiver checks the inverse.
    function automatic logic [LOUT-1:0] lift(input logic [LIN-1:0] x);
        return {^x, x};
    endfunction

endpackage

// File: rtl/csnc_role_buf.sv
// csnc_role_buf: one slot per role plus an occupancy bitmap.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/role/data   : store a packet in its role slot and mark it present
//   pop_en/pop_role   : clear the presence bit of a role that was sent
//   clr_all           : drop everything (wins over write and pop)
//   bitmap, count     : current occupancy and its population count
//   nxt_role/data/cnt : lowest present role, its data and the population
//                       count as they will be after this cycle's updates,
//                       so the caller can load registered outputs directly
module csnc_role_buf
    import csnc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ROLE_W-1:0] wr_role,
    input  logic [LOUT-1:0]   wr_data,
    input  logic              pop_en,
    input  logic [ROLE_W-1:0] pop_role,
    input  logic              clr_all,
    output logic [N-1:0]      bitmap,
    output logic [POP_W-1:0]  count,
    output logic [ROLE_W-1:0] nxt_role,
    output logic [LOUT-1:0]   nxt_data,
    output logic [POP_W-1:0]  nxt_count
);

    logic [N-1:0]    bitmap_r;
    logic [LOUT-1:0] buf_r [N];
    logic [N-1:0]    wr_oh_s;
    logic [N-1:0]    pop_oh_s;
    logic [N-1:0]    bitmap_nxt_s;

    // Decode write/pop roles and form the next occupancy bitmap.
    always_comb begin
        wr_oh_s  = '0;
        pop_oh_s = '0;
        for (int i = 0; i < N; i++) begin
            wr_oh_s[i]  = wr_en  && (wr_role  == ROLE_W'(i));
            pop_oh_s[i] = pop_en && (pop_role == ROLE_W'(i));
        end
        if (clr_all) begin
            bitmap_nxt_s = '0;
        end else begin
            bitmap_nxt_s = (bitmap_r | wr_oh_s) & ~pop_oh_s;
        end
    end

    // Lowest-set-bit picker and population counts; a packet being written
    // this cycle is bypassed so the pick sees it before it lands in buf_r.
    always_comb begin
        nxt_role  = '0;
        nxt_data  = '0;
        nxt_count = '0;
        count     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            nxt_role = bitmap_nxt_s[i] ? ROLE_W'(i) : nxt_role;
        end
        for (int i = 0; i < N; i++) begin
            nxt_data  = (nxt_role == ROLE_W'(i)) ? (wr_oh_s[i] ? wr_data : buf_r[i]) : nxt_data;
            nxt_count = nxt_count + POP_W'(bitmap_nxt_s[i]);
            count     = count + POP_W'(bitmap_r[i]);
        end
    end

    // Slot storage and occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_r <= '0;
            for (int i = 0; i < N; i++) begin
                buf_r[i] <= '0;
            end
        end else begin
            bitmap_r <= bitmap_nxt_s;
            for (int i = 0; i < N; i++) begin
                if (wr_oh_s[i]) begin
                    buf_r[i] <= wr_data;
                end
            end
        end
    end

    assign bitmap = bitmap_r;

endmodule

// File: rtl/csnc_rx_collector.sv
// csnc_rx_collector: receive-side collector for the k=3/n=5 CSNC code.
// Accepts role-tagged coded packets in any order, keeps the first K
// distinct parity-clean packets of a generation and streams them to the
// erasure decoder in ascending role order (tlast on the K-th beat).
// Ports:
//   aclk, areset                    : clock, synchronous active-high reset
//   s_axis_{tdata,role,tvalid,tlast}: channel input, s_axis_tready back
//   m_axis_{tdata,role,tvalid,tlast}: decoder output, m_axis_tready in
//   gen_ok / gen_fail               : one-cycle generation outcome pulses
//   ok_cnt, fail_cnt, drop_cnt,
//   par_err_cnt                     : saturating statistics counters
// TIMEOUT_CYC idle cycles with a partial generation abandon it (0 = off).
module csnc_rx_collector
    import csnc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [LOUT-1:0]   s_axis_tdata,
    input  logic [ROLE_W-1:0] s_axis_role,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [LOUT-1:0]   m_axis_tdata,
    output logic [ROLE_W-1:0] m_axis_role,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              gen_ok,
    output logic              gen_fail,
    output logic [CNT_W-1:0]  ok_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  par_err_cnt
);

    localparam int              TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic            TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

    state_t             state_r;
    logic               s_ready_r;
    logic [LOUT-1:0]    m_data_r;
    logic [ROLE_W-1:0]  m_role_r;
    logic               m_valid_r;
    logic               m_last_r;
    logic               gen_ok_r;
    logic               gen_fail_r;
    logic               last_seen_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [CNT_W-1:0]   ok_cnt_r;
    logic [CNT_W-1:0]   fail_cnt_r;
    logic [CNT_W-1:0]   drop_cnt_r;
    logic [CNT_W-1:0]   par_cnt_r;

    logic [N-1:0]       bitmap_s;
    logic [POP_W-1:0]   count_s;
    logic [ROLE_W-1:0]  nxt_role_s;
    logic [LOUT-1:0]    nxt_data_s;
    logic [POP_W-1:0]   nxt_count_s;

    logic               accept_s;
    logic               par_good_s;
    logic               role_in_range_s;
    logic [N-1:0]       role_oh_s;
    logic               beat_valid_s;
    logic               wr_en_s;
    logic               completes_s;
    logic               idle_tick_s;
    logic               tmo_fire_s;
    logic               fail_s;
    logic               hs_s;

    // Classify the incoming beat and derive this cycle's collector events.
    always_comb begin
        accept_s        = s_axis_tvalid & s_ready_r;
        par_good_s      = parity_ok(s_axis_tdata);
        role_in_range_s = (s_axis_role < ROLE_W'(N));
        if (role_in_range_s) begin
            role_oh_s = N'(1) << s_axis_role;
        end else begin
            role_oh_s = '0;
        end
        // A duplicate is a legal role whose slot is already occupied.
        beat_valid_s = par_good_s & role_in_range_s & ~(|(bitmap_s & role_oh_s));
        wr_en_s      = accept_s & (state_r == COLLECT) & beat_valid_s;
        completes_s  = wr_en_s & (count_s == POP_W'(K - 1));
        // Only partial generations age; an accepted beat always wins.
        idle_tick_s  = (state_r == COLLECT) & ~accept_s & (count_s != '0);
        tmo_fire_s   = TMO_EN & idle_tick_s & (tmo_r == TMO_LAST);
        fail_s       = ((accept_s & (state_r == COLLECT) & s_axis_tlast) & ~completes_s) | tmo_fire_s;
        hs_s         = (state_r == EMIT) & m_valid_r & m_axis_tready;
    end

    csnc_role_buf u_role_buf (
        .clk       (aclk),
        .rst       (areset),
        .wr_en     (wr_en_s),
        .wr_role   (s_axis_role),
        .wr_data   (s_axis_tdata),
        .pop_en    (hs_s),
        .pop_role  (m_role_r),
        .clr_all   (fail_s),
        .bitmap    (bitmap_s),
        .count     (count_s),
        .nxt_role  (nxt_role_s),
        .nxt_data  (nxt_data_s),
        .nxt_count (nxt_count_s)
    );

    // Collector FSM with registered stream outputs, pulses and statistics.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= COLLECT;
            s_ready_r   <= 1'b1;
            m_data_r    <= '0;
            m_role_r    <= '0;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            gen_ok_r    <= 1'b0;
            gen_fail_r  <= 1'b0;
            last_seen_r <= 1'b0;
            tmo_r       <= '0;
            ok_cnt_r    <= '0;
            fail_cnt_r  <= '0;
            drop_cnt_r  <= '0;
            par_cnt_r   <= '0;
        end else begin
            gen_ok_r   <= 1'b0;
            gen_fail_r <= 1'b0;
            case (state_r)
                COLLECT: begin
                    if (accept_s && !beat_valid_s) begin
                        drop_cnt_r <= sat_inc(drop_cnt_r);
                        if (!par_good_s) begin
                            par_cnt_r <= sat_inc(par_cnt_r);
                        end
                    end
                    if (accept_s || tmo_fire_s || !idle_tick_s) begin
                        tmo_r <= '0;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                    if (completes_s) begin
                        // Load the first output beat from the post-write pick.
                        state_r     <= EMIT;
                        s_ready_r   <= 1'b0;
                        last_seen_r <= s_axis_tlast;
                        m_valid_r   <= 1'b1;
                        m_data_r    <= nxt_data_s;
                        m_role_r    <= nxt_role_s;
                        m_last_r    <= (nxt_count_s == POP_W'(1));
                    end else if (fail_s) begin
                        gen_fail_r <= 1'b1;
                        fail_cnt_r <= sat_inc(fail_cnt_r);
                    end
                end
                EMIT: begin
                    if (hs_s) begin
                        if (m_last_r) begin
                            m_valid_r <= 1'b0;
                            m_last_r  <= 1'b0;
                            gen_ok_r  <= 1'b1;
                            ok_cnt_r  <= sat_inc(ok_cnt_r);
                            s_ready_r <= 1'b1;
                            state_r   <= last_seen_r ? COLLECT : DISCARD;
                        end else begin
                            m_data_r <= nxt_data_s;
                            m_role_r <= nxt_role_s;
                            m_last_r <= (nxt_count_s == POP_W'(1));
                        end
                    end
                end
                DISCARD: begin
                    if (accept_s && s_axis_tlast) begin
                        state_r <= COLLECT;
                    end
                end
                default: begin
                    state_r   <= COLLECT;
                    s_ready_r <= 1'b1;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tdata  = m_data_r;
    assign m_axis_role   = m_role_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tlast  = m_last_r;
    assign gen_ok        = gen_ok_r;
    assign gen_fail      = gen_fail_r;
    assign ok_cnt        = ok_cnt_r;
    assign fail_cnt      = fail_cnt_r;
    assign drop_cnt      = drop_cnt_r;
    assign par_err_cnt   = par_cnt_r;

endmodule
